// File: rtl/dragonfang_pkg.sv
// dragonfang_pkg: shared types for the dragonfang vector pipeline.
//   data_packet_t            - one vector register worth of data
//   VREG_ADDR_WIDTH          - architectural vector register address width
//   operand_fetch_state_t    - operand-fetch FSM states
//   operand_fetch_request_t  - decoded request latched by operand fetch
//   group_last_index()       - highest member index of an LMUL group
package dragonfang_pkg;

  localparam int unsigned DATA_WIDTH        = 64;
  localparam int unsigned VREG_ADDR_WIDTH   = 5;
  localparam int unsigned GROUP_INDEX_WIDTH = 3;

  typedef logic [DATA_WIDTH-1:0] data_packet_t;

  typedef enum logic [2:0] {
    OF_IDLE,
    OF_SRC,
    OF_AUX,
    OF_LATCH,
    OF_ISSUE
  } operand_fetch_state_t;

  typedef struct packed {
    logic [VREG_ADDR_WIDTH-1:0] vs1_address;
    logic [VREG_ADDR_WIDTH-1:0] vs2_address;
    logic [VREG_ADDR_WIDTH-1:0] vd_address;
    logic [1:0]                 lmul_log2;
    logic                       vm;
  } operand_fetch_request_t;

  // LMUL = 1 << lmul_log2, so the last member index is LMUL-1 (0..7).
  function automatic logic [GROUP_INDEX_WIDTH-1:0] group_last_index(input logic [1:0] lmul_log2);
    return GROUP_INDEX_WIDTH'((4'd1 << lmul_log2) - 4'd1);
  endfunction

endpackage

// File: rtl/vector_operand_fetch.sv
// vector_operand_fetch: sequential operand-fetch stage of the vector pipeline.
// Accepts one decoded instruction, walks its register group (LMUL 1/2/4/8)
// and reads vs1/vs2, then vd_old/v0, through the register file's two
// synchronous read ports. Each group member leaves as one operand beat on a
// valid/ready handshake.
//
// Build option: DRAGONFANG_V0_FETCH_EN
//   defined   - v0 is read on port b in AUX and used when vm = 0
//               (all-ones when vm = 1).
//   undefined - v0 is constant all-ones; vm is latched but not used.
//
// Ports:
//   clock, reset                           clock, synchronous active-high reset
//   request_valid / request_ready          instruction handshake (ready only in IDLE)
//   vs1_address, vs2_address, vd_address   group base registers
//   lmul_log2, vm                          group size code, 1 = unmasked
//   rf_read_address_a/b, rf_read_data_a/b  register file ports (1-cycle read latency)
//   operands_valid / operands_ready        operand beat handshake
//   vs1_data, vs2_data, vd_old, v0         registered operands
//   group_index, group_last                member index, final-beat flag
module vector_operand_fetch
  import dragonfang_pkg::*;
#(
  parameter int unsigned VREG_COUNT = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          request_valid,
  output logic                          request_ready,
  input  logic [$clog2(VREG_COUNT)-1:0] vs1_address,
  input  logic [$clog2(VREG_COUNT)-1:0] vs2_address,
  input  logic [$clog2(VREG_COUNT)-1:0] vd_address,
  input  logic [1:0]                    lmul_log2,
  input  logic                          vm,
  output logic [$clog2(VREG_COUNT)-1:0] rf_read_address_a,
  output logic [$clog2(VREG_COUNT)-1:0] rf_read_address_b,
  input  data_packet_t                  rf_read_data_a,
  input  data_packet_t                  rf_read_data_b,
  output logic                          operands_valid,
  input  logic                          operands_ready,
  output data_packet_t                  vs1_data,
  output data_packet_t                  vs2_data,
  output data_packet_t                  vd_old,
  output data_packet_t                  v0,
  output logic [2:0]                    group_index,
  output logic                          group_last
);

  localparam int unsigned AW = $clog2(VREG_COUNT);

  operand_fetch_state_t   r_state;
  operand_fetch_request_t r_req;
  logic [2:0]             r_index;
  logic [AW-1:0]          r_rf_addr_a;
  logic [AW-1:0]          r_rf_addr_b;
  logic                   r_request_ready;
  logic                   r_operands_valid;
  logic                   r_group_last;
  data_packet_t           r_vs1;
  data_packet_t           r_vs2;
  data_packet_t           r_vd_old;
  data_packet_t           r_v0;

  logic [2:0]             w_index_next;
  logic                   w_is_last;

  assign w_index_next = r_index + 3'd1;
  assign w_is_last    = (r_index == group_last_index(r_req.lmul_log2));

`ifndef DRAGONFANG_V0_FETCH_EN
  logic w_unused_vm;
  assign w_unused_vm = r_req.vm;
`endif

  // Read addresses are registered one state ahead: the value set on the
  // transition into SRC/AUX is what the register file sees in that state,
  // so its data returns in the following state (AUX/LATCH).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= OF_IDLE;
      r_req            <= '0;
      r_index          <= '0;
      r_rf_addr_a      <= '0;
      r_rf_addr_b      <= '0;
      r_request_ready  <= 1'b1;
      r_operands_valid <= 1'b0;
      r_group_last     <= 1'b0;
      r_vs1            <= '0;
      r_vs2            <= '0;
      r_vd_old         <= '0;
      r_v0             <= '0;
    end else begin
      case (r_state)
        OF_IDLE: begin
          if (request_valid) begin
            r_req           <= '{vs1_address: vs1_address,
                                 vs2_address: vs2_address,
                                 vd_address:  vd_address,
                                 lmul_log2:   lmul_log2,
                                 vm:          vm};
            r_index         <= '0;
            r_rf_addr_a     <= vs1_address;
            r_rf_addr_b     <= vs2_address;
            r_request_ready <= 1'b0;
            r_state         <= OF_SRC;
          end
        end

        OF_SRC: begin
          r_rf_addr_a <= r_req.vd_address + AW'(r_index);
          // v0 always lives in register 0; reading it unconditionally is
          // harmless when the masking feature is compiled out.
          r_rf_addr_b <= '0;
          r_state     <= OF_AUX;
        end

        OF_AUX: begin
          r_vs1       <= rf_read_data_a;
          r_vs2       <= rf_read_data_b;
          r_rf_addr_a <= '0;
          r_rf_addr_b <= '0;
          r_state     <= OF_LATCH;
        end

        OF_LATCH: begin
          r_vd_old <= rf_read_data_a;
`ifdef DRAGONFANG_V0_FETCH_EN
          r_v0     <= r_req.vm ? '1 : rf_read_data_b;
`else
          r_v0     <= '1;
`endif
          r_group_last     <= w_is_last;
          r_operands_valid <= 1'b1;
          r_state          <= OF_ISSUE;
        end

        OF_ISSUE: begin
          if (operands_ready) begin
            r_operands_valid <= 1'b0;
            r_group_last     <= 1'b0;
            if (w_is_last) begin
              r_index         <= '0;
              r_request_ready <= 1'b1;
              r_state         <= OF_IDLE;
            end else begin
              r_index     <= w_index_next;
              r_rf_addr_a <= r_req.vs1_address + AW'(w_index_next);
              r_rf_addr_b <= r_req.vs2_address + AW'(w_index_next);
              r_state     <= OF_SRC;
            end
          end
        end

        default: begin
          r_state          <= OF_IDLE;
          r_request_ready  <= 1'b1;
          r_operands_valid <= 1'b0;
        end
      endcase
    end
  end

  assign request_ready     = r_request_ready;
  assign rf_read_address_a = r_rf_addr_a;
  assign rf_read_address_b = r_rf_addr_b;
  assign operands_valid    = r_operands_valid;
  assign vs1_data          = r_vs1;
  assign vs2_data          = r_vs2;
  assign vd_old            = r_vd_old;
  assign v0                = r_v0;
  assign group_index       = r_index;
  assign group_last        = r_group_last;

endmodule

// File: tb/tb_vector_operand_fetch.sv
module tb_vector_operand_fetch;
  import dragonfang_pkg::*;

  logic         clock;
  logic         reset;
  logic         request_valid;
  logic         request_ready;
  logic [4:0]   vs1_address, vs2_address, vd_address;
  logic [1:0]   lmul_log2;
  logic         vm;
  logic [4:0]   rf_read_address_a, rf_read_address_b;
  data_packet_t rf_read_data_a, rf_read_data_b;
  logic         operands_valid;
  logic         operands_ready;
  data_packet_t vs1_data, vs2_data, vd_old, v0;
  logic [2:0]   group_index;
  logic         group_last;

  vector_operand_fetch #(.VREG_COUNT(32)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready),
    .vs1_address(vs1_address), .vs2_address(vs2_address), .vd_address(vd_address),
    .lmul_log2(lmul_log2), .vm(vm),
    .rf_read_address_a(rf_read_address_a), .rf_read_address_b(rf_read_address_b),
    .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
    .operands_valid(operands_valid), .operands_ready(operands_ready),
    .vs1_data(vs1_data), .vs2_data(vs2_data), .vd_old(vd_old), .v0(v0),
    .group_index(group_index), .group_last(group_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: synchronous read, data one cycle after address.
  logic [63:0] mem [32];
  always @(posedge clock) begin
    rf_read_data_a <= mem[rf_read_address_a];
    rf_read_data_b <= mem[rf_read_address_b];
  end

  int checks;
  int errors;

  // Chained-request hook: drive the next request during the last ISSUE.
  bit         g_chain;
  logic [4:0] g_n1, g_n2, g_nd;
  logic [1:0] g_nl;
  logic       g_nvm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic init_mem_rep();
    for (int n = 0; n < 32; n++) mem[n] = {8{8'(n)}};
  endtask

  task automatic init_mem_rand();
    for (int n = 0; n < 32; n++) mem[n] = {$urandom, $urandom};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(request_ready), 64'd1);
    chk({tag, "_valid"},     64'(operands_valid), 64'd0);
    chk({tag, "_vs1"},       vs1_data, 64'd0);
    chk({tag, "_vs2"},       vs2_data, 64'd0);
    chk({tag, "_vdold"},     vd_old, 64'd0);
    chk({tag, "_v0"},        v0, 64'd0);
    chk({tag, "_gidx"},      64'(group_index), 64'd0);
    chk({tag, "_glast"},     64'(group_last), 64'd0);
    chk({tag, "_addr_a"},    64'(rf_read_address_a), 64'd0);
    chk({tag, "_addr_b"},    64'(rf_read_address_b), 64'd0);
  endtask

  // Expected beat j of a group, from the register-group rules.
  task automatic check_beat(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                            input logic [1:0] lm, input logic [63:0] exp_v0, input int j);
    logic [4:0] r1, r2, rd;
    r1 = a1 + 5'(j);
    r2 = a2 + 5'(j);
    rd = ad + 5'(j);
    chk("beat_valid",     64'(operands_valid), 64'd1);
    chk("beat_req_ready", 64'(request_ready), 64'd0);
    chk("beat_vs1",       vs1_data, mem[r1]);
    chk("beat_vs2",       vs2_data, mem[r2]);
    chk("beat_vdold",     vd_old, mem[rd]);
    chk("beat_v0",        v0, exp_v0);
    chk("beat_gidx",      64'(group_index), 64'(j));
    chk("beat_glast",     64'(group_last), 64'(j == (1 << lm) - 1));
    chk("beat_addr_a",    64'(rf_read_address_a), 64'd0);
    chk("beat_addr_b",    64'(rf_read_address_b), 64'd0);
  endtask

  // Runs one whole group. bp < 0 selects a random 0..3 cycle stall per beat.
  // preissued: request inputs were already raised by the previous group.
  task automatic run_group(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                           input logic [1:0] lm, input logic vmi, input int bp, input bit preissued,
                           output logic [63:0] first_vs1, output logic [63:0] last_vs1);
    int n, e, hold;
    logic [63:0] exp_v0;
    logic [4:0]  ea, eb;
    n = 1 << lm;
    first_vs1 = '0;
    last_vs1  = '0;
`ifdef DRAGONFANG_V0_FETCH_EN
    exp_v0 = vmi ? '1 : mem[0];
`else
    exp_v0 = '1;
`endif
    @(negedge clock);
    chk("idle_req_ready", 64'(request_ready), 64'd1);
    chk("idle_valid", 64'(operands_valid), 64'd0);
    if (!preissued) begin
      vs1_address = a1; vs2_address = a2; vd_address = ad;
      lmul_log2 = lm; vm = vmi; request_valid = 1'b1;
    end
    @(posedge clock); #1;
    request_valid = 1'b0;
    // The latched request must not follow later input changes.
    vs1_address = 5'($urandom); vs2_address = 5'($urandom); vd_address = 5'($urandom);
    lmul_log2 = 2'($urandom); vm = 1'($urandom);
    for (int j = 0; j < n; j++) begin
      e = 0;
      while (1) begin
        @(negedge clock);
        if (operands_valid || e > 8) break;
        case (e)
          0:       begin ea = a1 + 5'(j); eb = a2 + 5'(j); end
          1:       begin ea = ad + 5'(j); eb = 5'd0; end
          default: begin ea = 5'd0; eb = 5'd0; end
        endcase
        chk("fetch_addr_a", 64'(rf_read_address_a), 64'(ea));
        chk("fetch_addr_b", 64'(rf_read_address_b), 64'(eb));
        chk("fetch_req_ready", 64'(request_ready), 64'd0);
        @(posedge clock);
        e++;
      end
      chk("beat_latency", 64'(e), 64'd3);
      if (!operands_valid) return;
      check_beat(a1, a2, ad, lm, exp_v0, j);
      if (j == 0) first_vs1 = vs1_data;
      if (j == n - 1) last_vs1 = vs1_data;
      hold = (bp < 0) ? int'($urandom_range(0, 3)) : bp;
      for (int k = 0; k < hold; k++) begin
        @(posedge clock);
        @(negedge clock);
        check_beat(a1, a2, ad, lm, exp_v0, j);
      end
      if (g_chain && j == n - 1) begin
        vs1_address = g_n1; vs2_address = g_n2; vd_address = g_nd;
        lmul_log2 = g_nl; vm = g_nvm; request_valid = 1'b1;
        g_chain = 1'b0;
      end
      operands_ready = 1'b1;
      @(posedge clock); #1;
      operands_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [4:0]  vs1, vs2, vd;
    logic [1:0]  lmul;
    logic        vm;
    int          bp;
    logic [63:0] exp_first_vs1;
    logic [63:0] exp_last_vs1;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [63:0] f, l;
    logic [4:0]  r1, r2, rd;
    logic [1:0]  rl;
    logic        rv;
    checks = 0;
    errors = 0;
    g_chain = 1'b0;
    reset = 1'b1;
    request_valid = 1'b0;
    operands_ready = 1'b0;
    vs1_address = '0; vs2_address = '0; vd_address = '0;
    lmul_log2 = '0; vm = 1'b0;
    init_mem_rep();

    tbl[0] = '{5'd3,  5'd5,  5'd7,  2'd0, 1'b0, 0, 64'h0303030303030303, 64'h0303030303030303};
    tbl[1] = '{5'd30, 5'd2,  5'd4,  2'd2, 1'b0, 0, 64'h1e1e1e1e1e1e1e1e, 64'h0101010101010101};
    tbl[2] = '{5'd8,  5'd16, 5'd24, 2'd1, 1'b1, 5, 64'h0808080808080808, 64'h0909090909090909};
    tbl[3] = '{5'd31, 5'd0,  5'd12, 2'd3, 1'b1, 0, 64'h1f1f1f1f1f1f1f1f, 64'h0606060606060606};
    tbl[4] = '{5'd0,  5'd31, 5'd1,  2'd1, 1'b0, 2, 64'h0000000000000000, 64'h0101010101010101};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_group(tbl[t].vs1, tbl[t].vs2, tbl[t].vd, tbl[t].lmul, tbl[t].vm, tbl[t].bp, 1'b0, f, l);
      chk("tbl_first_vs1", f, tbl[t].exp_first_vs1);
      chk("tbl_last_vs1",  l, tbl[t].exp_last_vs1);
    end

    // Back-to-back: second request raised during the last ISSUE of the first.
    g_chain = 1'b1;
    g_n1 = 5'd20; g_n2 = 5'd21; g_nd = 5'd22; g_nl = 2'd1; g_nvm = 1'b0;
    run_group(5'd10, 5'd11, 5'd12, 2'd0, 1'b1, 0, 1'b0, f, l);
    run_group(5'd20, 5'd21, 5'd22, 2'd1, 1'b0, 0, 1'b1, f, l);
    chk("b2b_last_vs1", l, 64'h1515151515151515);

    // Reset in AUX of the second member of an LMUL=2 group.
    @(negedge clock);
    vs1_address = 5'd4; vs2_address = 5'd9; vd_address = 5'd14;
    lmul_log2 = 2'd1; vm = 1'b0; request_valid = 1'b1;
    @(posedge clock); #1;
    request_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_beat0_valid", 64'(operands_valid), 64'd1);
    chk("rst_beat0_vs1", vs1_data, 64'h0404040404040404);
    operands_ready = 1'b1;
    @(posedge clock); #1;
    operands_ready = 1'b0;
    @(negedge clock);
    chk("rst_src_addr_a", 64'(rf_read_address_a), 64'd5);
    @(posedge clock);
    @(negedge clock);
    chk("rst_aux_addr_a", 64'(rf_read_address_a), 64'd15);
    reset = 1'b1;
    operands_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_reset_outputs("midreset");
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk("midreset_no_beat", 64'(operands_valid), 64'd0);
      chk("midreset_idle", 64'(request_ready), 64'd1);
    end
    operands_ready = 1'b0;

    // Reset wins over a request handshake in the same cycle.
    @(negedge clock);
    vs1_address = 5'd21; vs2_address = 5'd22; vd_address = 5'd23;
    lmul_log2 = 2'd0; request_valid = 1'b1; reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    request_valid = 1'b0;
    reset = 1'b0;
    chk("rst_vs_req_addr_a", 64'(rf_read_address_a), 64'd0);
    chk("rst_vs_req_ready", 64'(request_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk("rst_vs_req_no_beat", 64'(operands_valid), 64'd0);
    end

    // Randomized groups with random register contents and stalls.
    for (int t = 0; t < 40; t++) begin
      init_mem_rand();
      r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
      rl = 2'($urandom); rv = 1'($urandom);
      run_group(r1, r2, rd, rl, rv, -1, 1'b0, f, l);
      chk("rand_last_vs1", l, mem[r1 + 5'((1 << rl) - 1)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
